// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder shared across all bit positions by serial_add_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder walked LSB-first over WIDTH cycles, valid/ready on both sides.
// Optional SERIAL_ADD_SUB_EN adds a `sub` input selecting a-b (cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH:0]   sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction as a + ~b + 1; cin is deliberately ignored in that mode.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // New sum bit enters at the MSB; the wide concat keeps WIDTH==1 legal.
  assign sum_shift = {fa_s, sum_sr};

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .cin(carry),
    .s  (fa_s),
    .c  (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b_load;
            carry    <= c_load;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift[WIDTH:1];
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= sum_shift[WIDTH:1];
            cout      <= fa_c;
          end
        end
        DONE: begin
          // A new in_valid here is not taken; acceptance waits for IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
